fetch_unit: RTL

- Instruction fetch stage and the producer side of the decode interface.
- Holds the PC and issues word reads to instruction memory.
- Buffers returned 16-bit instructions in a small prefetch FIFO and presents them as `instr`/`instr_valid` to decode_unit.
- Honours decode backpressure (`stall`) and branch redirects (`is_branch_taken` plus `branch_target`). A redirect flushes buffered and in-flight instructions.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: instruction/PC widths, the NOP encoding and
// the fetch-entry payload handed from fetch to decode.
package cpu_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned PC_W    = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries with push/pop/flush and full/empty/count.
// Flush has priority over push and pop in the same cycle.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
)(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_push,
    input  fetch_entry_t                     i_data,
    input  logic                             i_pop,
    input  logic                             i_flush,
    output fetch_entry_t                     o_head,
    output logic                             o_full,
    output logic                             o_empty,
    output logic [$clog2(DEPTH + 1)-1:0]     o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is accepted only when the head leaves this cycle
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited word reads, prefetch FIFO and redirect
// flush. Define FETCH_PERF_EN to add saturating perf counters.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = 16'h0000,
    parameter int unsigned     DEPTH     = 2,
    parameter int unsigned     MAX_OUTST = 2
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               is_branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [PC_W-1:0]    instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_bubbles,
    output logic [15:0]        perf_flushes
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = 5;

    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  r_track_pc;
    logic [2:0]       r_outst;
    logic [2:0]       r_discard;
    logic [2:0]       w_outst_nxt;
    logic [CNT_W-1:0] w_count;
    logic             w_empty;
    logic             w_full;
    logic             w_credit;
    logic             w_accept;
    logic             w_rsp;
    logic             w_push;
    logic             w_pop;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_data;

    // Occupancy plus in-flight reads may never exceed the FIFO depth
    assign w_credit = ((SUM_W'(w_count) + SUM_W'(r_outst)) < SUM_W'(DEPTH)) &&
                      (4'(r_outst) < 4'(MAX_OUTST));

    assign imem_req    = reset && !is_branch_taken && w_credit;
    assign imem_addr   = r_pc;
    assign w_accept    = imem_req && imem_ready;
    assign w_rsp       = imem_rvalid && (r_outst != 3'd0);
    assign w_pop       = !w_empty && !stall;
    assign w_push      = w_rsp && (r_discard == 3'd0) && !is_branch_taken && (!w_full || w_pop);
    assign w_outst_nxt = r_outst + 3'(w_accept) - 3'(w_rsp);
    assign w_push_data = '{pc: r_track_pc, instr: imem_rdata};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_track_pc <= RESET_PC;
            r_outst    <= 3'd0;
            r_discard  <= 3'd0;
        end else begin
            r_outst <= w_outst_nxt;
            if (is_branch_taken) begin
                // Every read still in flight after this cycle belongs to the old path
                r_pc       <= branch_target;
                r_track_pc <= branch_target;
                r_discard  <= w_outst_nxt;
            end else begin
                if (w_accept) r_pc <= r_pc + PC_W'(1);
                if (w_push)   r_track_pc <= r_track_pc + PC_W'(1);
                if (w_rsp && (r_discard != 3'd0)) r_discard <= r_discard - 3'd1;
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (is_branch_taken),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign instr_valid = !w_empty;
    assign instr       = w_empty ? NOP_INSTR : w_head.instr;
    assign instr_pc    = w_empty ? '0 : w_head.pc;

`ifdef FETCH_PERF_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= 16'd0;
            perf_bubbles <= 16'd0;
            perf_flushes <= 16'd0;
        end else begin
            if (w_pop)                 perf_fetched <= sat_inc(perf_fetched);
            if (!instr_valid && !stall) perf_bubbles <= sat_inc(perf_bubbles);
            if (is_branch_taken)       perf_flushes <= sat_inc(perf_flushes);
        end
    end
`endif

endmodule
